// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
// Macro ALU_SEQ_MUL_EN adds the MUL state to the state enum.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_MOV = 4'd5,
    OP_SLL = 4'd6,
    OP_ROL = 4'd7,
    OP_SRL = 4'd8,
    OP_SRA = 4'd9,
    OP_MUL = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
`ifdef ALU_SEQ_MUL_EN
    , ST_MUL = 2'd3
`endif
  } state_e;

  localparam int FLAG_S = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_ROL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Flag former shared by every ALU path: S/Z from the result, C/V passed in.
// An illegal opcode forces all flags to zero, including Z.
module alu_seq_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] res_i,
  input  logic             c_i,
  input  logic             v_i,
  input  logic             illegal_i,
  output logic [3:0]       flags_o
);

  always_comb begin
    flags_o = '0;
    if (!illegal_i) begin
      flags_o[FLAG_C] = c_i;
      flags_o[FLAG_V] = v_i;
      flags_o[FLAG_Z] = (res_i == '0);
      flags_o[FLAG_S] = res_i[WIDTH-1];
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic ops, bit-serial shifts,
// and an optional shift-add multiplier enabled by macro ALU_SEQ_MUL_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] shl_res;
  logic             shl_c;
  logic [WIDTH-1:0] fl_res;
  logic             fl_c, fl_v, fl_ill;
  logic [3:0]       fl_out;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, acc_nxt;
  logic [WIDTH-1:0]   mp_q, mp_d;
  assign acc_nxt = mp_q[0] ? (acc_q + mc_q) : acc_q;
`endif

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  // One-bit shift step of the working register; C is the bit that falls out.
  always_comb begin
    shl_res = work_q;
    shl_c   = 1'b0;
    case (op_q)
      OP_SLL: begin shl_res = {work_q[MSB-1:0], 1'b0};       shl_c = work_q[MSB]; end
      OP_ROL: begin shl_res = {work_q[MSB-1:0], work_q[MSB]}; shl_c = 1'b0;       end
      OP_SRL: begin shl_res = {1'b0, work_q[MSB:1]};          shl_c = work_q[0];   end
      OP_SRA: begin shl_res = {work_q[MSB], work_q[MSB:1]};   shl_c = work_q[0];   end
      default: begin shl_res = work_q; shl_c = 1'b0; end
    endcase
  end

  // Select what the shared flag former sees in the current state.
  always_comb begin
    fl_res = '0;
    fl_c   = 1'b0;
    fl_v   = 1'b0;
    fl_ill = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (op)
          OP_ADD: begin
            fl_res = sum_w[MSB:0];
            fl_c   = sum_w[WIDTH];
            fl_v   = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
          end
          OP_SUB: begin
            fl_res = diff_w[MSB:0];
            fl_c   = diff_w[WIDTH];
            fl_v   = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
          end
          OP_AND: fl_res = a & b;
          OP_OR:  fl_res = a | b;
          OP_XOR: fl_res = a ^ b;
          OP_MOV: fl_res = b;
          OP_SLL, OP_ROL, OP_SRL, OP_SRA: fl_res = a;
`ifdef ALU_SEQ_MUL_EN
          OP_MUL: fl_res = '0;
`endif
          default: fl_ill = 1'b1;
        endcase
      end
      ST_SHIFT: begin
        fl_res = shl_res;
        fl_c   = shl_c;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        fl_res = acc_nxt[MSB:0];
        fl_c   = (acc_nxt[2*WIDTH-1:WIDTH] != '0);
      end
`endif
      default: fl_ill = 1'b0;
    endcase
  end

  alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
    .res_i     (fl_res),
    .c_i       (fl_c),
    .v_i       (fl_v),
    .illegal_i (fl_ill),
    .flags_o   (fl_out)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    count_d  = count_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          work_d  = a;
          count_d = b[SHW-1:0];
          err_d   = fl_ill;
          if (is_shift(op) && (b[SHW-1:0] != '0)) begin
            state_d = ST_SHIFT;
`ifdef ALU_SEQ_MUL_EN
          end else if (op == OP_MUL) begin
            acc_d   = '0;
            mc_d    = {{WIDTH{1'b0}}, a};
            mp_d    = b;
            count_d = '1;
            state_d = ST_MUL;
`endif
          end else begin
            result_d = fl_res;
            flags_d  = fl_out;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = shl_res;
        count_d = count_q - 1'b1;
        if (count_q == SHW'(1)) begin
          result_d = fl_res;
          flags_d  = fl_out;
          state_d  = ST_DONE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      // count runs from all-ones down to zero: WIDTH multiplier bits.
      ST_MUL: begin
        acc_d   = acc_nxt;
        mc_d    = mc_q << 1;
        mp_d    = mp_q >> 1;
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
          result_d = fl_res;
          flags_d  = fl_out;
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      count_q  <= count_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=16); the op-10 step follows macro ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs after accept, measure latency,
  // check the result, optionally stall the consumer, then take the result.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [15:0] av,
                       input logic [15:0] bv, input int exp_lat, input logic [15:0] exp_res,
                       input logic [3:0] exp_fl, input logic exp_err, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_flags"}, 32'(flags), 32'(exp_fl));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_result"}, 32'(result), 32'(exp_res));
      chk({tag, "_hold_flags"}, 32'(flags), 32'(exp_fl));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_taken_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_taken_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic quiet;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //        tag         op     a         b        lat res       {C,Z,V,S} err hold
    do_op("add_ovf",   4'd0,  16'h7FFF, 16'h0001, 1, 16'h8000, 4'b0011, 1'b0, 0);
    do_op("add_carry", 4'd0,  16'hFFFF, 16'h0001, 1, 16'h0000, 4'b1100, 1'b0, 0);
    do_op("sub_borrow",4'd1,  16'h0000, 16'h0001, 1, 16'hFFFF, 4'b1001, 1'b0, 0);
    do_op("sub_zero",  4'd1,  16'h1234, 16'h1234, 1, 16'h0000, 4'b0100, 1'b0, 0);
    do_op("sub_ovf",   4'd1,  16'h8000, 16'h0001, 1, 16'h7FFF, 4'b0010, 1'b0, 0);
    do_op("and",       4'd2,  16'hF0F0, 16'hFF00, 1, 16'hF000, 4'b0001, 1'b0, 0);
    do_op("or",        4'd3,  16'h00F0, 16'h0F00, 1, 16'h0FF0, 4'b0000, 1'b0, 0);
    do_op("xor",       4'd4,  16'h5555, 16'h5555, 1, 16'h0000, 4'b0100, 1'b0, 0);
    do_op("mov",       4'd5,  16'h1111, 16'h8000, 1, 16'h8000, 4'b0001, 1'b0, 0);
    do_op("sra4",      4'd9,  16'h8001, 16'h0004, 5, 16'hF800, 4'b0001, 1'b0, 0);
    do_op("sll1",      4'd6,  16'h8000, 16'h0001, 2, 16'h0000, 4'b1100, 1'b0, 0);
    do_op("srl2",      4'd8,  16'h000F, 16'h0002, 3, 16'h0003, 4'b1000, 1'b0, 0);
    do_op("rol1",      4'd7,  16'h8001, 16'h0001, 2, 16'h0003, 4'b0000, 1'b0, 0);
    do_op("sll0",      4'd6,  16'h1234, 16'h0010, 1, 16'h1234, 4'b0000, 1'b0, 0);
    do_op("hold_add",  4'd0,  16'h0001, 16'h0002, 1, 16'h0003, 4'b0000, 1'b0, 10);
    do_op("illegal12", 4'd12, 16'h0000, 16'h0000, 1, 16'h0000, 4'b0000, 1'b1, 0);
`ifdef ALU_SEQ_MUL_EN
    do_op("mul",       4'd10, 16'h0100, 16'h0100, 17, 16'h0000, 4'b1100, 1'b0, 0);
`else
    do_op("op10_ill",  4'd10, 16'h0100, 16'h0100, 1, 16'h0000, 4'b0000, 1'b1, 0);
`endif

    // Abort a long shift with reset; nothing may be delivered afterwards.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd6; a = 16'h0001; b = 16'h000F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_out_valid", 32'(out_valid), 32'd0);
    chk("abort_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    chk("abort_quiet", 32'(quiet), 32'd1);
    do_op("add_after", 4'd0, 16'h0002, 16'h0003, 1, 16'h0005, 4'b0000, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (legal values 8, 16, 32).
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount field width.
REQ-003 Port: clk  input  1  single clock; all state on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block accepts a request this cycle.
REQ-007 Port: op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 SLL, 7 ROL, 8 SRL, 9 SRA, 10 MUL, 11-15 illegal.
REQ-008 Port: a, b  input  WIDTH each  operands; shift amount is b[SHW-1:0].
REQ-009 Port: out_valid  input-side handshake output  1  result present.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: result  output  WIDTH  operation result.
REQ-012 Port: flags  output  4  {C,Z,V,S}, bit 3 = C, bit 0 = S.
REQ-013 Port: err  output  1  completed request had an illegal opcode.

Function
REQ-014 FSM states: IDLE, SHIFT, MUL, DONE; in_ready=1 only in IDLE.
REQ-015 Accept = in_valid & in_ready; a, b and op are captured on accept, and later input changes do not affect the operation.
REQ-016 ADD/SUB/AND/OR/XOR/MOV/illegal: IDLE->DONE; out_valid is asserted on the cycle after accept (latency 1).
REQ-017 Shifts: IDLE->SHIFT with count=b[SHW-1:0]; each SHIFT cycle shifts 1 bit and decrements count; count==0 -> DONE; latency = shamt+1, so shamt 0 gives latency 1 with result=a.
REQ-018 SLL fills with 0; SRL fills with 0; SRA fills with a[WIDTH-1]; ROL rotates left (the MSB re-enters at the LSB).
REQ-019 Shift C = last bit shifted out (SLL: MSB, SRL/SRA: LSB); ROL C=0; shamt 0 gives C=0; V=0 for all shifts.
REQ-020 ADD: C = unsigned carry out of the MSB; V = signed overflow (operands same sign, result sign differs).
REQ-021 SUB: result = a-b; C = borrow (a<b unsigned); V = signed overflow (operands differ in sign, result sign differs from a).
REQ-022 AND/OR/XOR/MOV (result=b): C=0, V=0.
REQ-023 All ops: S = result[WIDTH-1]; Z = (result==0).
REQ-024 Illegal opcode: result=0, flags=4'b0000 (Z also forced 0), err=1; err=0 for every legal op.
REQ-025 DONE: out_valid=1; result/flags/err held stable until out_valid & out_ready, then -> IDLE.
REQ-026 A new request is not accepted in the same cycle the result is taken; in_ready rises the following cycle (throughput: at most one op per latency+1 cycles).

Reset
REQ-027 rst_n low: state=IDLE, out_valid=0, in_ready=1 after release, result=0, flags=0, err=0, count=0.
REQ-028 Reset asserted mid-SHIFT/MUL/DONE aborts the operation; no result is delivered after release.

Configuration
REQ-029 Macro ALU_SEQ_MUL_EN defined: op 10 = shift-add multiply, IDLE->MUL, one multiplier bit per cycle, WIDTH MUL cycles, latency WIDTH+1; result = low WIDTH bits of the unsigned product; C = (high half != 0); V=0.
REQ-030 Macro undefined: no MUL state and no multiplier logic; op 10 behaves as illegal (REQ-024).

Structure
REQ-031 Shared package alu_pkg holds: opcode enum, state enum, flag bit-index constants (FLAG_S=0, FLAG_V=1, FLAG_Z=2, FLAG_C=3).
REQ-032 One sub-module, alu_seq_flags, computes S/Z from the result plus C/V from per-op inputs, and is reused by all paths.

Verification
REQ-033 WIDTH=16, ADD a=16'h7FFF b=16'h0001 -> 1-cycle latency, result 16'h8000, flags C0 Z0 V1 S1.
REQ-034 SUB a=16'h0000 b=16'h0001 -> result 16'hFFFF, C1 V0 S1; SUB a=b=16'h1234 -> result 0, Z1.
REQ-035 SRA a=16'h8001 b=4 -> out_valid 5 cycles after accept, result 16'hF800, C0; SLL a=16'h8000 b=1 -> result 0, C1, Z1.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0 throughout; op 12 -> err=1, result 0, flags 0.
REQ-037 ALU_SEQ_MUL_EN set, MUL a=16'h0100 b=16'h0100 -> latency 17, result 0, C1, Z1; macro unset, op 10 -> err=1 after 1 cycle.
REQ-038 Assert rst_n low during SHIFT (b=15) -> after release out_valid stays 0 and in_ready=1; next ADD 2+3 -> result 5.
